// File: rtl/life_generation_engine_if.sv
// Control and observation bundle for life_generation_engine.
// Latency: none; plain wires between the control stage and the engine.
// Backpressure: none. Control inputs are single-cycle pulses and are acted on every cycle they are sampled high.
// Ports:
//   load/seed_in          load a seed pattern ([row][col])
//   start/stop/step_once  run control pulses
//   grid_out/gen_count    current generation and saturating generation counter
//   running/stable/extinct status flags
interface life_generation_engine_if;
  logic            load;
  logic [7:0][7:0] seed_in;
  logic            start;
  logic            stop;
  logic            step_once;
  logic [7:0][7:0] grid_out;
  logic [15:0]     gen_count;
  logic            running;
  logic            stable;
  logic            extinct;

  modport master (
    output load, seed_in, start, stop, step_once,
    input  grid_out, gen_count, running, stable, extinct
  );

  modport slave (
    input  load, seed_in, start, stop, step_once,
    output grid_out, gen_count, running, stable, extinct
  );
endinterface

// File: rtl/life_generation_engine.sv
// 8x8 cellular-automaton generation engine (B/S rule masks, optional torus wrap).
// Latency: one generation per TICK_DIV cycles in RUN (first update TICK_DIV cycles after start), or next edge on step_once.
// Backpressure: none. Pulses act once per sampled cycle; priority load > stop > start > step_once > tick.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         life_generation_engine_if.slave (load/seed/run control in, grid and status out)
module life_generation_engine #(
  parameter int unsigned TICK_DIV  = 4,
  parameter bit          WRAP      = 1'b1,
  parameter logic [8:0]  B_MASK    = 9'b000001000,
  parameter logic [8:0]  S_MASK    = 9'b000001100,
  parameter bit          AUTO_HALT = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  life_generation_engine_if.slave bus
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0][7:0] r_grid;
  logic [15:0]     r_gen_count;
  logic [15:0]     r_prescale;
  logic            r_stable;

  logic [7:0][7:0] w_next_grid;
  logic [3:0]      w_nbr;
  int              w_rr;
  int              w_cc;
  logic            w_same;
  logic            w_adv;
  logic            w_load;
  logic            w_clr_stable;
  logic [15:0]     w_presc_nxt;

  // Whole next generation from the current register only, so every cell
  // sees the same (old) grid. The low 3 bits of a -1/8 offset are exactly
  // the modulo-8 index, so wrapping needs no extra arithmetic.
  always_comb begin
    w_next_grid = '0;
    w_nbr       = '0;
    w_rr        = 0;
    w_cc        = 0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        w_nbr = '0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              w_rr = r + dr;
              w_cc = c + dc;
              if (WRAP || (w_rr >= 0 && w_rr < 8 && w_cc >= 0 && w_cc < 8)) begin
                w_nbr = w_nbr + {3'b000, r_grid[w_rr[2:0]][w_cc[2:0]]};
              end
            end
          end
        end
        w_next_grid[r][c] = r_grid[r][c] ? S_MASK[w_nbr] : B_MASK[w_nbr];
      end
    end
  end

  assign w_same = (w_next_grid == r_grid);

  // Control decode; commands that are ignored in the current state fall
  // through to the lower-priority ones (e.g. start in RUN still lets the tick run).
  always_comb begin
    w_state_nxt  = r_state;
    w_presc_nxt  = r_prescale;
    w_adv        = 1'b0;
    w_load       = 1'b0;
    w_clr_stable = 1'b0;
    if (bus.load) begin
      w_load      = 1'b1;
      w_state_nxt = ST_IDLE;
      w_presc_nxt = '0;
    end else if (bus.stop) begin
      w_state_nxt = ST_IDLE;
      w_presc_nxt = '0;
    end else if (bus.start && r_state != ST_RUN) begin
      w_state_nxt  = ST_RUN;
      w_presc_nxt  = '0;
      w_clr_stable = 1'b1;
    end else if (bus.step_once && r_state != ST_RUN) begin
      w_adv = 1'b1;
    end else if (r_state == ST_RUN) begin
      if (r_prescale == TICK_LAST) begin
        w_adv       = 1'b1;
        w_presc_nxt = '0;
        if (w_same && AUTO_HALT) begin
          w_state_nxt = ST_HALTED;
        end
      end else begin
        w_presc_nxt = r_prescale + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grid      <= '0;
      r_gen_count <= '0;
      r_prescale  <= '0;
      r_stable    <= 1'b0;
    end else begin
      r_prescale <= w_presc_nxt;
      if (w_load) begin
        r_grid      <= bus.seed_in;
        r_gen_count <= '0;
        r_stable    <= 1'b0;
      end else if (w_adv) begin
        r_grid   <= w_next_grid;
        r_stable <= w_same;
        if (r_gen_count != 16'hFFFF) begin
          r_gen_count <= r_gen_count + 16'd1;
        end
      end else if (w_clr_stable) begin
        r_stable <= 1'b0;
      end
    end
  end

  assign bus.grid_out  = r_grid;
  assign bus.gen_count = r_gen_count;
  assign bus.running   = (r_state == ST_RUN);
  assign bus.stable    = r_stable;
  assign bus.extinct   = (r_grid == '0);

endmodule

// File: tb/tb_life_generation_engine.sv
module tb_life_generation_engine;
  typedef logic [7:0][7:0] grid_t;
  typedef struct {
    string       tag;
    logic [63:0] val;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  life_generation_engine_if if_a ();
  life_generation_engine_if if_b ();

  // A: bounded grid, auto-halt, prescaled run.  B: torus, free-running every cycle.
  life_generation_engine #(.TICK_DIV(4), .WRAP(1'b0), .AUTO_HALT(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave)
  );
  life_generation_engine #(.TICK_DIV(1), .WRAP(1'b1), .AUTO_HALT(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave)
  );

  sb_t sb[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  // Reference next-generation model (B3/S23).
  function automatic grid_t next_gen(input grid_t g, input bit wrap);
    grid_t      nx;
    int         n, rr, cc;
    logic [8:0] bm;
    logic [8:0] sm;
    bm = 9'b000001000;
    sm = 9'b000001100;
    nx = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              rr = r + dr;
              cc = c + dc;
              if (wrap) begin
                rr = (rr + 8) % 8;
                cc = (cc + 8) % 8;
                n  = n + int'(g[rr][cc]);
              end else if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8) begin
                n = n + int'(g[rr][cc]);
              end
            end
          end
        end
        nx[r][c] = g[r][c] ? sm[n] : bm[n];
      end
    end
    return nx;
  endfunction

  task automatic push(input string t, input logic [63:0] v);
    sb_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    sb_t e;
    n_checks++;
    if (sb.size() == 0) begin
      $display("FAIL sb_empty: observed %h with no expectation queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) n_pass++;
      else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
    end
  endtask

  function automatic logic [63:0] o_grid(input int d);
    return (d == 0) ? 64'(if_a.grid_out) : 64'(if_b.grid_out);
  endfunction
  function automatic logic [63:0] o_cnt(input int d);
    return (d == 0) ? 64'(if_a.gen_count) : 64'(if_b.gen_count);
  endfunction
  function automatic logic [63:0] o_run(input int d);
    return (d == 0) ? 64'(if_a.running) : 64'(if_b.running);
  endfunction
  function automatic logic [63:0] o_stb(input int d);
    return (d == 0) ? 64'(if_a.stable) : 64'(if_b.stable);
  endfunction
  function automatic logic [63:0] o_ext(input int d);
    return (d == 0) ? 64'(if_a.extinct) : 64'(if_b.extinct);
  endfunction

  task automatic clear_inputs();
    if_a.load = 1'b0; if_a.start = 1'b0; if_a.stop = 1'b0; if_a.step_once = 1'b0;
    if_b.load = 1'b0; if_b.start = 1'b0; if_b.stop = 1'b0; if_b.step_once = 1'b0;
  endtask

  // Drive one cycle of control on DUT d; returns 1 time unit after the sampling edge.
  task automatic apply(input int d, input logic ld, input logic st, input logic sp,
                       input logic so, input grid_t sd);
    if (d == 0) begin
      if_a.load = ld; if_a.start = st; if_a.stop = sp; if_a.step_once = so; if_a.seed_in = sd;
    end else begin
      if_b.load = ld; if_b.start = st; if_b.stop = sp; if_b.step_once = so; if_b.seed_in = sd;
    end
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  grid_t z, bl, bv, bk, sd, gl, gl4, gm;

  initial begin
    z  = '0;
    bl = '0; bl[3] = 8'h1C;
    bv = '0; bv[2] = 8'h08; bv[3] = 8'h08; bv[4] = 8'h08;
    bk = '0; bk[3] = 8'h18; bk[4] = 8'h18;
    sd = '0; sd[0] = 8'h01;
    gl = '0; gl[0] = 8'h02; gl[1] = 8'h04; gl[2] = 8'h07;
    gl4 = '0; gl4[1] = 8'h04; gl4[2] = 8'h08; gl4[3] = 8'h0E;

    rst_n = 1'b0;
    clear_inputs();
    if_a.seed_in = '0;
    if_b.seed_in = '0;

    // Reset state
    #12;
    push("rst_grid", 64'(z)); push("rst_gen", 64'd0); push("rst_run", 64'd0);
    push("rst_ext", 64'd1);   push("rst_stb", 64'd0);
    chk(o_grid(0)); chk(o_cnt(0)); chk(o_run(0)); chk(o_ext(0)); chk(o_stb(0));
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    // Blinker, bounded grid, single steps
    push("bl_load", 64'(bl));
    apply(0, 1, 0, 0, 0, bl);
    chk(o_grid(0));
    push("bl_g1", 64'(bv)); push("bl_c1", 64'd1); push("bl_s1", 64'd0);
    apply(0, 0, 0, 0, 1, z);
    chk(o_grid(0)); chk(o_cnt(0)); chk(o_stb(0));
    push("bl_g2", 64'(bl)); push("bl_c2", 64'd2);
    apply(0, 0, 0, 0, 1, z);
    chk(o_grid(0)); chk(o_cnt(0));

    // Block still-life, prescaled run and auto-halt
    apply(0, 1, 0, 0, 0, bk);
    apply(0, 0, 1, 0, 0, z);
    push("bk_cnt_pre", 64'd0); push("bk_run_pre", 64'd1);
    idle(3);
    chk(o_cnt(0)); chk(o_run(0));
    push("bk_grid", 64'(bk)); push("bk_cnt", 64'd1); push("bk_stb", 64'd1); push("bk_run", 64'd0);
    idle(1);
    chk(o_grid(0)); chk(o_cnt(0)); chk(o_stb(0)); chk(o_run(0));
    push("bk_halt_step_cnt", 64'd2); push("bk_halt_step_run", 64'd0);
    apply(0, 0, 0, 0, 1, z);
    chk(o_cnt(0)); chk(o_run(0));

    // Single cell at the corner, bounded grid
    apply(0, 1, 0, 0, 0, sd);
    push("db_grid", 64'(z)); push("db_ext", 64'd1); push("db_stb1", 64'd0);
    apply(0, 0, 0, 0, 1, z);
    chk(o_grid(0)); chk(o_ext(0)); chk(o_stb(0));
    push("db_stb2", 64'd1); push("db_cnt2", 64'd2);
    apply(0, 0, 0, 0, 1, z);
    chk(o_stb(0)); chk(o_cnt(0));

    // Load and start together: load wins
    push("ls_grid", 64'(bl)); push("ls_run", 64'd0); push("ls_cnt", 64'd0);
    apply(0, 1, 1, 0, 0, bl);
    chk(o_grid(0)); chk(o_run(0)); chk(o_cnt(0));
    push("ls_idle_cnt", 64'd0);
    idle(5);
    chk(o_cnt(0));

    // Asynchronous reset mid-prescale
    apply(0, 0, 0, 0, 1, z);
    apply(0, 0, 1, 0, 0, z);
    push("pre_rst_cnt", 64'd1); push("pre_rst_run", 64'd1);
    idle(2);
    chk(o_cnt(0)); chk(o_run(0));
    #3 rst_n = 1'b0;
    push("arst_grid", 64'(z)); push("arst_cnt", 64'd0); push("arst_run", 64'd0);
    #1;
    chk(o_grid(0)); chk(o_cnt(0)); chk(o_run(0));
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single cell on the torus
    apply(1, 1, 0, 0, 0, sd);
    push("tdb_grid", 64'(z)); push("tdb_ext", 64'd1);
    apply(1, 0, 0, 0, 1, z);
    chk(o_grid(1)); chk(o_ext(1));
    push("tdb_stb", 64'd1);
    apply(1, 0, 0, 0, 1, z);
    chk(o_stb(1));

    // Glider on the torus, an update every cycle
    apply(1, 1, 0, 0, 0, gl);
    apply(1, 0, 1, 0, 0, z);
    gm = gl;
    for (int i = 0; i < 4; i++) gm = next_gen(gm, 1'b1);
    push("gl4_shift", 64'(gl4)); push("gl4_model", 64'(gm)); push("gl4_cnt", 64'd4);
    idle(4);
    chk(o_grid(1)); chk(o_grid(1)); chk(o_cnt(1));
    push("gl32_grid", 64'(gl)); push("gl32_cnt", 64'd32); push("gl32_run", 64'd1);
    idle(28);
    chk(o_grid(1)); chk(o_cnt(1)); chk(o_run(1));

    // Counter saturation on a free-running blinker, then stop
    apply(1, 0, 0, 1, 0, z);
    apply(1, 1, 0, 0, 0, bl);
    apply(1, 0, 1, 0, 0, z);
    push("sat_cnt", 64'hFFFF); push("sat_run", 64'd1); push("sat_grid", 64'(bl));
    idle(65540);
    chk(o_cnt(1)); chk(o_run(1)); chk(o_grid(1));
    push("stop_run", 64'd0); push("stop_grid", 64'(bl)); push("stop_cnt", 64'hFFFF);
    apply(1, 0, 0, 1, 0, z);
    chk(o_run(1)); chk(o_grid(1)); chk(o_cnt(1));
    push("stop_hold", 64'(bl));
    idle(3);
    chk(o_grid(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
